fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the pipelined CPU. It issues sequential fetch requests to the instruction cache over the req/ok handshake and buffers returned instructions with their PC and PC+4 in a DEPTH-entry queue. The decode stage drains the queue through a valid/ready interface. Branch/jump redirects flush the queue and discard the in-flight cache response. It replaces the single IF/ID register and decouples fetch from decode stalls.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/sync_fifo.sv | 100 ++++++++++
 rtl/fetch_queue.sv | 128 ++++++++++++
 tb/tb_fetch_queue.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch front end: the instruction-word
// width, the default reset fetch address and the fetch FSM state encoding.
package cpu_pkg;

  localparam int INSN_WIDTH = 32;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_002C;

  // Fetch FSM encoding. IDLE waits for queue space, REQ has a live request
  // whose data will be queued, DROP has a request whose data must be thrown away.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_DROP = 2'b10;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head. The head entry is presented from
// its own register so that consumers see clean registered outputs. Flush
// empties the queue in one cycle and takes priority over push and pop.
module sync_fifo #(
  parameter int DW    = 96,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DW-1:0]                push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         head_valid,
  output logic [DW-1:0]                head_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r, rd_ptr_next_s;
  logic [AW-1:0] wr_ptr_r, wr_ptr_next_s;
  logic [CW-1:0] count_r, count_next_s;
  logic          head_valid_r, head_valid_next_s;
  logic [DW-1:0] head_data_r, head_data_next_s;
  logic          push_s, pop_s;

  // Next-state computation for pointers, occupancy and the registered head.
  always_comb begin
    push_s            = push & (count_r != CW'(DEPTH));
    pop_s             = pop & (count_r != {CW{1'b0}});
    rd_ptr_next_s     = rd_ptr_r;
    wr_ptr_next_s     = wr_ptr_r;
    count_next_s      = count_r;
    head_valid_next_s = head_valid_r;
    head_data_next_s  = head_data_r;
    if (flush) begin
      rd_ptr_next_s     = {AW{1'b0}};
      wr_ptr_next_s     = {AW{1'b0}};
      count_next_s      = {CW{1'b0}};
      head_valid_next_s = 1'b0;
    end else begin
      if (pop_s) begin
        rd_ptr_next_s = rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_next_s = rd_ptr_r;
      end
      if (push_s) begin
        wr_ptr_next_s = wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_next_s = wr_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_next_s = count_r + CW'(1);
        2'b01:   count_next_s = count_r - CW'(1);
        default: count_next_s = count_r;
      endcase
      head_valid_next_s = (count_next_s != {CW{1'b0}});
      // The incoming word becomes the head when nothing older will remain.
      if (push_s && ((count_r == {CW{1'b0}}) || (pop_s && (count_r == CW'(1))))) begin
        head_data_next_s = push_data;
      end else if (pop_s && (count_next_s != {CW{1'b0}})) begin
        head_data_next_s = mem_r[rd_ptr_next_s];
      end else begin
        head_data_next_s = head_data_r;
      end
    end
  end

  // Storage array; written only on an accepted push that is not being flushed.
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer, occupancy and head registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r     <= {AW{1'b0}};
      wr_ptr_r     <= {AW{1'b0}};
      count_r      <= {CW{1'b0}};
      head_valid_r <= 1'b0;
      head_data_r  <= {DW{1'b0}};
    end else begin
      rd_ptr_r     <= rd_ptr_next_s;
      wr_ptr_r     <= wr_ptr_next_s;
      count_r      <= count_next_s;
      head_valid_r <= head_valid_next_s;
      head_data_r  <= head_data_next_s;
    end
  end

  assign count      = count_r;
  assign head_valid = head_valid_r;
  assign head_data  = head_data_r;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end. Issues sequential fetches to the icache (one
// outstanding at a time), queues {instruction, PC, PC+4} for decode, and on a
// redirect flushes the queue and throws away the response of any request that
// was already in flight.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int               WIDTH    = INSN_WIDTH,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         i_req,
  output logic [WIDTH-1:0]             i_addr,
  input  logic [WIDTH-1:0]             i_read_data,
  input  logic                         i_ok,
  input  logic                         redirect,
  input  logic [WIDTH-1:0]             redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_ir,
  output logic [WIDTH-1:0]             out_pc,
  output logic [WIDTH-1:0]             out_npc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int FW = 3 * WIDTH;

  logic [1:0]       state_r, state_next_s;
  logic [WIDTH-1:0] fpc_r, fpc_next_s, fpc_plus4_s;
  logic [WIDTH-1:0] addr_r, addr_next_s;
  logic [WIDTH-1:0] new_pc_s;
  logic             i_req_r;
  logic             push_s, pop_s;
  logic [CW-1:0]    fifo_count_s, count_next_s;
  logic             head_valid_s;
  logic [FW-1:0]    head_data_s;
  logic             unused_s;

  // Redirect targets are word aligned; the low bits are deliberately dropped.
  assign unused_s = ^redirect_pc[1:0];

  // Queue handshake and the occupancy the FSM will see after this cycle.
  always_comb begin
    fpc_plus4_s  = fpc_r + WIDTH'(4);
    new_pc_s     = {redirect_pc[WIDTH-1:2], 2'b00};
    push_s       = (state_r == ST_REQ) & i_ok & ~redirect;
    pop_s        = head_valid_s & out_ready & ~redirect;
    count_next_s = fifo_count_s + CW'(push_s) - CW'(pop_s);
  end

  // Fetch FSM and fetch PC; redirect overrides all normal sequencing.
  always_comb begin
    state_next_s = state_r;
    fpc_next_s   = fpc_r;
    if (redirect) begin
      fpc_next_s = new_pc_s;
      case (state_r)
        ST_IDLE:          state_next_s = ST_REQ;
        ST_REQ, ST_DROP:  state_next_s = i_ok ? ST_REQ : ST_DROP;
        default:          state_next_s = ST_IDLE;
      endcase
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (count_next_s < CW'(DEPTH)) begin
            state_next_s = ST_REQ;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_REQ: begin
          if (i_ok) begin
            fpc_next_s   = fpc_plus4_s;
            state_next_s = (count_next_s < CW'(DEPTH)) ? ST_REQ : ST_IDLE;
          end else begin
            state_next_s = ST_REQ;
          end
        end
        ST_DROP: state_next_s = i_ok ? ST_REQ : ST_DROP;
        default: state_next_s = ST_IDLE;
      endcase
    end
    // While a stale request is pending the icache must keep seeing its address.
    addr_next_s = (state_next_s == ST_DROP) ? addr_r : fpc_next_s;
  end

  // FSM, fetch PC and registered icache request outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      fpc_r   <= RESET_PC;
      addr_r  <= RESET_PC;
      i_req_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      fpc_r   <= fpc_next_s;
      addr_r  <= addr_next_s;
      i_req_r <= (state_next_s == ST_REQ) | (state_next_s == ST_DROP);
    end
  end

  sync_fifo #(
    .DW    (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_data  ({i_read_data, fpc_r, fpc_plus4_s}),
    .pop        (pop_s),
    .flush      (redirect),
    .count      (fifo_count_s),
    .head_valid (head_valid_s),
    .head_data  (head_data_s)
  );

  assign i_req     = i_req_r;
  assign i_addr    = addr_r;
  assign out_valid = head_valid_s;
  assign out_ir    = head_data_s[FW-1:2*WIDTH];
  assign out_pc    = head_data_s[2*WIDTH-1:WIDTH];
  assign out_npc   = head_data_s[WIDTH-1:0];
  assign count     = fifo_count_s;

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed corner sequences, a redirect vector
// table and a randomized run, all checked against a transaction-level model
// (a queue of expected PCs plus the expected fetch stream position).
module tb_fetch_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req;
  logic [WIDTH-1:0]  i_addr;
  logic [WIDTH-1:0]  i_read_data;
  logic              i_ok;
  logic              redirect;
  logic [WIDTH-1:0]  redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_ir;
  logic [WIDTH-1:0]  out_pc;
  logic [WIDTH-1:0]  out_npc;
  logic [CW-1:0]     count;

  always #5 clk = ~clk;

  fetch_queue #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_002C)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_read_data (i_read_data),
    .i_ok        (i_ok),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ir      (out_ir),
    .out_pc      (out_pc),
    .out_npc     (out_npc),
    .count       (count)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: PCs expected in the queue, next PC of the fetch stream,
  // and whether the outstanding request predates the last redirect.
  logic [31:0] q[$];
  logic [31:0] model_pc;
  logic [31:0] stale_addr;
  logic        stale;
  int          n_push;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] pc0;
    logic [31:0] npc0;
    logic [31:0] pc1;
  } vec_t;
  vec_t vecs[4];

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    model_pc   = 32'h0000_002C;
    stale      = 1'b0;
    stale_addr = 32'h0000_0000;
  endtask

  // Assert reset mid-cycle, check the asynchronous reset values, release later.
  task automatic do_reset();
    rst       = 1'b1;
    redirect  = 1'b0;
    i_ok      = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("rst_i_req",     {31'd0, i_req},      32'd0);
    chk("rst_i_addr",    i_addr,              32'h0000_002C);
    chk("rst_out_valid", {31'd0, out_valid},  32'd0);
    chk("rst_out_ir",    out_ir,              32'd0);
    chk("rst_out_pc",    out_pc,              32'd0);
    chk("rst_out_npc",   out_npc,             32'd0);
    chk("rst_count",     32'(count),          32'd0);
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One clock cycle: pre-edge checks against the model, edge, model update,
  // post-edge occupancy checks. Inputs are whatever the caller has set.
  task automatic step();
    logic        pre_req;
    logic [31:0] pre_addr;
    i_read_data = insn_of(i_addr);
    pre_req     = i_req;
    pre_addr    = i_addr;
    if (q.size() > 0) begin
      chk("head_pc",  out_pc,  q[0]);
      chk("head_npc", out_npc, q[0] + 32'd4);
      chk("head_ir",  out_ir,  insn_of(q[0]));
    end
    if (q.size() == DEPTH) begin
      chk("full_no_req", {31'd0, i_req}, 32'd0);
    end
    if (stale) begin
      chk("drop_req",  {31'd0, pre_req}, 32'd1);
      chk("drop_addr", pre_addr, stale_addr);
    end else if (pre_req) begin
      chk("fetch_addr", pre_addr, model_pc);
    end
    @(posedge clk); #1;
    if (redirect) begin
      if (!stale) begin
        stale_addr = model_pc;
      end
      stale    = pre_req & ~i_ok;
      q.delete();
      model_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (out_ready && q.size() > 0) begin
        void'(q.pop_front());
      end
      if (pre_req && i_ok) begin
        if (stale) begin
          stale = 1'b0;
        end else begin
          q.push_back(model_pc);
          model_pc = model_pc + 32'd4;
          n_push++;
        end
      end
    end
    chk("out_valid", {31'd0, out_valid}, {31'd0, (q.size() != 0)});
    chk("count",     32'(count),         32'(q.size()));
  endtask

  initial begin
    vecs[0] = '{rpc: 32'h0000_0103, pc0: 32'h0000_0100, npc0: 32'h0000_0104, pc1: 32'h0000_0104};
    vecs[1] = '{rpc: 32'hFFFF_FFFE, pc0: 32'hFFFF_FFFC, npc0: 32'h0000_0000, pc1: 32'h0000_0000};
    vecs[2] = '{rpc: 32'h8000_0001, pc0: 32'h8000_0000, npc0: 32'h8000_0004, pc1: 32'h8000_0004};
    vecs[3] = '{rpc: 32'h0000_0002, pc0: 32'h0000_0000, npc0: 32'h0000_0004, pc1: 32'h0000_0004};

    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; i_ok = 1'b0;
    i_read_data = 32'd0; out_ready = 1'b0; n_push = 0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // First request appears one edge after reset release.
    chk("req_before_first_edge", {31'd0, i_req}, 32'd0);
    step();
    chk("first_req",  {31'd0, i_req}, 32'd1);
    chk("first_addr", i_addr, 32'h0000_002C);

    // Fill with decode stalled: exactly DEPTH pushes, then the request drops.
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      i_ok = i_req;
      step();
    end
    i_ok = 1'b0;
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_req",   {31'd0, i_req}, 32'd0);
    chk("fill_head",  out_pc, 32'h0000_002C);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("refill_req",  {31'd0, i_req}, 32'd1);
    chk("refill_addr", i_addr, 32'h0000_003C);
    chk("pop_count",   32'(count), 32'd3);
    chk("pop_head",    out_pc, 32'h0000_0030);

    // Redirect while a request is pending, response delayed three cycles.
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    step();
    redirect = 1'b0;
    chk("redir_valid", {31'd0, out_valid}, 32'd0);
    chk("redir_count", 32'(count), 32'd0);
    chk("drop_hold_addr0", i_addr, 32'h0000_003C);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("drop_hold_addr", i_addr, 32'h0000_003C);
      chk("drop_hold_req",  {31'd0, i_req}, 32'd1);
    end
    i_ok = 1'b1;
    step();
    i_ok = 1'b0;
    chk("drop_discard_count", 32'(count), 32'd0);
    chk("after_drop_addr",    i_addr, 32'h0000_0100);

    // Push and pop in the same cycle at count 2.
    out_ready = 1'b0; i_ok = 1'b1;
    step();
    step();
    chk("two_count", 32'(count), 32'd2);
    out_ready = 1'b1;
    step();
    chk("pushpop_count", 32'(count), 32'd2);
    chk("pushpop_head",  out_pc, 32'h0000_0104);

    // Redirect coincident with i_ok; unaligned target.
    redirect = 1'b1; redirect_pc = 32'h0000_0103; out_ready = 1'b0;
    step();
    redirect = 1'b0; i_ok = 1'b0;
    chk("coinc_valid", {31'd0, out_valid}, 32'd0);
    chk("coinc_addr",  i_addr, 32'h0000_0100);
    chk("coinc_req",   {31'd0, i_req}, 32'd1);

    // Redirect vector table: alignment and PC wrap.
    for (int v = 0; v < 4; v++) begin
      redirect = 1'b1; redirect_pc = vecs[v].rpc; i_ok = 1'b0; out_ready = 1'b0;
      step();
      redirect = 1'b0;
      for (int k = 0; k < 20 && q.size() < 2; k++) begin
        i_ok = i_req;
        step();
      end
      i_ok = 1'b0;
      chk("vec_fill_count", 32'(count), 32'd2);
      chk("vec_pc0",  out_pc,  vecs[v].pc0);
      chk("vec_npc0", out_npc, vecs[v].npc0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("vec_pc1", out_pc, vecs[v].pc1);
    end

    // Reset while a stale request is pending.
    i_ok = 1'b0;
    for (int k = 0; k < 4 && !i_req; k++) begin
      step();
    end
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    redirect = 1'b0;
    step();
    chk("pre_rst_drop_req",  {31'd0, i_req}, 32'd1);
    chk("pre_rst_drop_addr", i_addr, stale_addr);
    #3;
    do_reset();

    // Randomized traffic against the model.
    n_push = 0;
    for (int c = 0; c < 3000; c++) begin
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      out_ready   = ($urandom_range(0, 3) != 0);
      i_ok        = i_req & ($urandom_range(0, 2) != 0);
      step();
    end
    redirect = 1'b0; i_ok = 1'b0;
    chk("random_progress", {31'd0, (n_push > 100)}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
